pht_predictor: RTL and testbench

- Sits directly downstream of the branch history cache.
- Consumes the cache's per-PC 3-bit history and read_hit and produces a taken/not-taken prediction from a pattern history table (PHT) of 2-bit saturating counters.
- Holds in-flight predictions in a small FIFO until the branch resolves, then trains the PHT and drives the cache's update port (we / branch_taken / update_pc).

---
 rtl/pht_pkg.sv | 50 +++++
 rtl/pht_inflight_fifo.sv | 77 +++++++
 rtl/pht_predictor.sv | 142 ++++++++++++++
 tb/tb_pht_predictor.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pht_pkg.sv
// -----------------------------------------------------------------------------
// pht_pkg -- shared types and helpers for the PHT branch predictor slice.
//
// Contents:
//   PC_W, HIST_W, IDX_PC_BITS, IDX_W, FIFO_DEPTH : geometry of the predictor
//   ctr_t       : 2-bit saturating counter state (SNT/WNT/WT/ST)
//   CTR_INIT    : counter value after reset (weakly not-taken)
//   inflight_t  : one in-flight prediction {pc, idx, pred}
//   ctr_inc / ctr_dec / ctr_train : saturating counter updates
//
// The in-flight record width is fixed here, so changing PC or history width
// is done in this package rather than by overriding top-level parameters.
// -----------------------------------------------------------------------------
package pht_pkg;

  localparam int PC_W        = 10;
  localparam int HIST_W      = 3;
  localparam int IDX_PC_BITS = 4;
  localparam int IDX_W       = IDX_PC_BITS + HIST_W;
  localparam int PHT_ENTRIES = 1 << IDX_W;
  localparam int FIFO_DEPTH  = 4;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_t;

  localparam ctr_t CTR_INIT = WNT;

  typedef struct packed {
    logic [PC_W-1:0]  pc;
    logic [IDX_W-1:0] idx;
    logic             pred;
  } inflight_t;

  function automatic ctr_t ctr_inc(input ctr_t c);
    return (c == ST) ? ST : ctr_t'(c + 2'd1);
  endfunction

  function automatic ctr_t ctr_dec(input ctr_t c);
    return (c == SNT) ? SNT : ctr_t'(c - 2'd1);
  endfunction

  function automatic ctr_t ctr_train(input ctr_t c, input logic taken);
    return taken ? ctr_inc(c) : ctr_dec(c);
  endfunction

endpackage

// File: rtl/pht_inflight_fifo.sv
// -----------------------------------------------------------------------------
// pht_inflight_fifo -- synchronous FIFO of in-flight predictions.
//
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   push, push_data : enqueue request and record
//   pop             : dequeue request (ignored when empty)
//   flush           : drop every entry at the clock edge
//   head            : oldest record (valid only when !empty)
//   full, empty     : occupancy flags
//
// A push while full is accepted when a pop happens in the same cycle, since
// the pop frees the slot the push needs. DEPTH must be a power of 2, >= 2,
// so the pointers wrap by natural overflow.
// -----------------------------------------------------------------------------
module pht_inflight_fifo
  import pht_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  inflight_t push_data,
  input  logic      pop,
  input  logic      flush,
  output inflight_t head,
  output logic      full,
  output logic      empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  inflight_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // NOTE: every variable written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    count_next = count;
    if (do_push && !do_pop) count_next = count + 1'b1;
    if (do_pop && !do_push) count_next = count - 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
    end
  end

  // NOTE: the storage array has no reset; an entry is only read after it was
  // written, and occupancy alone decides validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/pht_predictor.sv
// -----------------------------------------------------------------------------
// pht_predictor -- pattern-history-table branch predictor behind the branch
// history cache.
//
// Lookup side:
//   lookup_valid, lookup_pc, lookup_history, lookup_hit : request from cache
//   lookup_ready : FIFO can take the request (!full || resolve_valid)
//   pred_valid, pred_taken : registered prediction, one cycle after accept
// Resolve side:
//   resolve_valid, resolve_taken : outcome of the oldest in-flight branch
//   flush        : squash every in-flight entry
//   mispredict   : one-cycle pulse, resolved outcome != stored prediction
//   upd_we, upd_branch_taken, upd_pc : cache update port
//   err_underflow: sticky, a resolve arrived with nothing in flight
// Statistics (build macro PHT_PRED_STATS_EN):
//   stat_resolved, stat_mispred : saturating 16-bit counters; tied to 0 when
//   the macro is not defined.
//
// clk, rst: clock and synchronous active-high reset.
// -----------------------------------------------------------------------------
module pht_predictor
  import pht_pkg::*;
#(
  parameter int FIFO_DEPTH_P = FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lookup_valid,
  input  logic [PC_W-1:0]   lookup_pc,
  input  logic [HIST_W-1:0] lookup_history,
  input  logic              lookup_hit,
  output logic              lookup_ready,
  output logic              pred_valid,
  output logic              pred_taken,
  input  logic              resolve_valid,
  input  logic              resolve_taken,
  input  logic              flush,
  output logic              mispredict,
  output logic              upd_we,
  output logic              upd_branch_taken,
  output logic [PC_W-1:0]   upd_pc,
  output logic              err_underflow,
  output logic [15:0]       stat_resolved,
  output logic [15:0]       stat_mispred
);

  ctr_t             pht [PHT_ENTRIES];
  logic [IDX_W-1:0] lookup_idx;
  logic             lookup_pred;
  logic             accept;
  logic             pop;
  logic             head_mispred;
  inflight_t        push_rec;
  inflight_t        head;
  logic             fifo_full;
  logic             fifo_empty;

  // A cache miss carries no trustworthy history, so only the PC selects the
  // counter group in that case.
  assign lookup_idx  = {lookup_pc[IDX_PC_BITS-1:0],
                        lookup_hit ? lookup_history : HIST_W'(0)};
  // The table is read before this edge's training write, so a lookup hitting
  // the entry being trained sees the old counter.
  assign lookup_pred = pht[lookup_idx][1];

  assign lookup_ready = !fifo_full || resolve_valid;
  // A flush in the same cycle squashes the lookup along with the FIFO.
  assign accept       = lookup_valid && lookup_ready && !flush;
  assign pop          = resolve_valid && !fifo_empty;
  assign head_mispred = head.pred != resolve_taken;

  assign push_rec.pc   = lookup_pc;
  assign push_rec.idx  = lookup_idx;
  assign push_rec.pred = lookup_pred;

  pht_inflight_fifo #(
    .DEPTH (FIFO_DEPTH_P)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (accept),
    .push_data (push_rec),
    .pop       (resolve_valid),
    .flush     (flush),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Unlike the FIFO storage, the counters hold architectural state and must
  // start from a known value.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PHT_ENTRIES; i++) pht[i] <= CTR_INIT;
    end else if (pop) begin
      pht[head.idx] <= ctr_train(pht[head.idx], resolve_taken);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pred_valid       <= 1'b0;
      pred_taken       <= 1'b0;
      mispredict       <= 1'b0;
      upd_we           <= 1'b0;
      upd_branch_taken <= 1'b0;
      upd_pc           <= '0;
      err_underflow    <= 1'b0;
    end else begin
      pred_valid       <= accept;
      pred_taken       <= accept && lookup_pred;
      mispredict       <= pop && head_mispred;
      upd_we           <= pop;
      upd_branch_taken <= pop && resolve_taken;
      if (pop) upd_pc <= head.pc;
      if (resolve_valid && fifo_empty) err_underflow <= 1'b1;
    end
  end

`ifdef PHT_PRED_STATS_EN
  logic [15:0] stat_resolved_q;
  logic [15:0] stat_mispred_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_resolved_q <= '0;
      stat_mispred_q  <= '0;
    end else if (pop) begin
      if (stat_resolved_q != 16'hFFFF) stat_resolved_q <= stat_resolved_q + 16'd1;
      if (head_mispred && stat_mispred_q != 16'hFFFF)
        stat_mispred_q <= stat_mispred_q + 16'd1;
    end
  end

  assign stat_resolved = stat_resolved_q;
  assign stat_mispred  = stat_mispred_q;
`else
  assign stat_resolved = '0;
  assign stat_mispred  = '0;
`endif

endmodule

// File: tb/tb_pht_predictor.sv
// -----------------------------------------------------------------------------
// tb_pht_predictor -- self-checking bench for pht_predictor.
// A behavioural model (integer counter array + queue of in-flight records)
// predicts every output; a directed table, hand-written corner sequences and
// random traffic are all checked against it. Define PHT_PRED_STATS_EN for
// both RTL and bench to exercise the statistics counters.
// -----------------------------------------------------------------------------
module tb_pht_predictor;

  logic       clk = 1'b0;
  logic       rst;
  logic       lookup_valid;
  logic [9:0] lookup_pc;
  logic [2:0] lookup_history;
  logic       lookup_hit;
  logic       lookup_ready;
  logic       pred_valid;
  logic       pred_taken;
  logic       resolve_valid;
  logic       resolve_taken;
  logic       flush;
  logic       mispredict;
  logic       upd_we;
  logic       upd_branch_taken;
  logic [9:0] upd_pc;
  logic       err_underflow;
  logic [15:0] stat_resolved;
  logic [15:0] stat_mispred;

  always #5 clk = ~clk;

  pht_predictor dut (
    .clk              (clk),
    .rst              (rst),
    .lookup_valid     (lookup_valid),
    .lookup_pc        (lookup_pc),
    .lookup_history   (lookup_history),
    .lookup_hit       (lookup_hit),
    .lookup_ready     (lookup_ready),
    .pred_valid       (pred_valid),
    .pred_taken       (pred_taken),
    .resolve_valid    (resolve_valid),
    .resolve_taken    (resolve_taken),
    .flush            (flush),
    .mispredict       (mispredict),
    .upd_we           (upd_we),
    .upd_branch_taken (upd_branch_taken),
    .upd_pc           (upd_pc),
    .err_underflow    (err_underflow),
    .stat_resolved    (stat_resolved),
    .stat_mispred     (stat_mispred)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int pc;
    int idx;
    bit pred;
  } rec_t;

  int   m_pht [128];
  rec_t m_q [$];
  bit   e_pv, e_pt, e_mis, e_we, e_bt, e_err;
  int   e_upc, e_sr, e_sm;

  task automatic model_reset();
    foreach (m_pht[i]) m_pht[i] = 1;
    m_q.delete();
    e_pv = 0; e_pt = 0; e_mis = 0; e_we = 0; e_bt = 0; e_err = 0;
    e_upc = 0; e_sr = 0; e_sm = 0;
  endtask

  // One clock cycle: drive inputs, check lookup_ready before the edge, update
  // the model, then compare every registered output just after the edge.
  task automatic step(input bit r, input bit lv, input int pc, input int hist,
                      input bit hit, input bit rv, input bit rt, input bit fl);
    int  idx;
    bit  pred, accept, can_pop;
    rec_t h;
    rst = r; lookup_valid = lv; lookup_pc = pc[9:0]; lookup_history = hist[2:0];
    lookup_hit = hit; resolve_valid = rv; resolve_taken = rt; flush = fl;
    #1;
    check("lookup_ready", lookup_ready, (m_q.size() < 4) || rv);
    if (r) begin
      model_reset();
    end else begin
      idx     = ((pc % 16) * 8) + (hit ? (hist % 8) : 0);
      pred    = m_pht[idx] >= 2;
      accept  = lv && ((m_q.size() < 4) || rv) && !fl;
      can_pop = rv && (m_q.size() > 0);
      e_we = can_pop; e_mis = 0; e_bt = 0;
      if (can_pop) begin
        h = m_q.pop_front();
        e_mis = (h.pred != rt);
        e_bt  = rt;
        e_upc = h.pc;
        m_pht[h.idx] = rt ? ((m_pht[h.idx] == 3) ? 3 : m_pht[h.idx] + 1)
                          : ((m_pht[h.idx] == 0) ? 0 : m_pht[h.idx] - 1);
`ifdef PHT_PRED_STATS_EN
        if (e_sr < 65535) e_sr++;
        if (e_mis && e_sm < 65535) e_sm++;
`endif
      end
      if (rv && !can_pop) e_err = 1;
      if (accept) m_q.push_back('{pc: pc % 1024, idx: idx, pred: pred});
      if (fl) m_q.delete();
      e_pv = accept;
      e_pt = accept && pred;
    end
    @(posedge clk);
    #1;
    check("pred_valid",       pred_valid,       e_pv);
    check("pred_taken",       pred_taken,       e_pt);
    check("mispredict",       mispredict,       e_mis);
    check("upd_we",           upd_we,           e_we);
    check("upd_branch_taken", upd_branch_taken, e_bt);
    check("upd_pc",           upd_pc,           e_upc);
    check("err_underflow",    err_underflow,    e_err);
    check("stat_resolved",    stat_resolved,    e_sr);
    check("stat_mispred",     stat_mispred,     e_sm);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit lv; int pc; int hist; bit hit; bit rv; bit rt; bit fl;
    bit pv; bit pt; bit mis; bit we; int upc;
  } vec_t;

  vec_t vecs [14];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // lookup then resolve cycles walking one counter WNT -> WT -> ST -> ST -> WT
    vecs[0]  = '{1, 'h013, 5, 1, 0, 0, 0, 1, 0, 0, 0, 0};
    vecs[1]  = '{0, 'h000, 0, 0, 1, 1, 0, 0, 0, 1, 1, 'h013};
    vecs[2]  = '{1, 'h013, 5, 1, 0, 0, 0, 1, 1, 0, 0, 0};
    vecs[3]  = '{0, 'h000, 0, 0, 1, 1, 0, 0, 0, 0, 1, 'h013};
    vecs[4]  = '{1, 'h013, 5, 1, 0, 0, 0, 1, 1, 0, 0, 0};
    vecs[5]  = '{0, 'h000, 0, 0, 1, 1, 0, 0, 0, 0, 1, 'h013};
    vecs[6]  = '{1, 'h013, 5, 1, 0, 0, 0, 1, 1, 0, 0, 0};
    vecs[7]  = '{0, 'h000, 0, 0, 1, 0, 0, 0, 0, 1, 1, 'h013};
    // miss forces history bits to zero: index 0x28 vs 0x2F with a hit
    vecs[8]  = '{1, 'h025, 7, 0, 0, 0, 0, 1, 0, 0, 0, 0};
    vecs[9]  = '{1, 'h025, 7, 1, 0, 0, 0, 1, 0, 0, 0, 0};
    vecs[10] = '{0, 'h000, 0, 0, 1, 1, 0, 0, 0, 1, 1, 'h025};
    vecs[11] = '{0, 'h000, 0, 0, 1, 1, 0, 0, 0, 1, 1, 'h025};
    vecs[12] = '{1, 'h025, 3, 0, 0, 0, 0, 1, 1, 0, 0, 0};
    vecs[13] = '{0, 'h000, 0, 0, 1, 1, 0, 0, 0, 0, 1, 'h025};

    model_reset();
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    check("reset_ready", lookup_ready, 1);
    check("reset_pred_valid", pred_valid, 0);

    foreach (vecs[i]) begin
      step(0, vecs[i].lv, vecs[i].pc, vecs[i].hist, vecs[i].hit,
           vecs[i].rv, vecs[i].rt, vecs[i].fl);
      check($sformatf("vec%0d_pred_valid", i), pred_valid, vecs[i].pv);
      check($sformatf("vec%0d_pred_taken", i), pred_taken, vecs[i].pt);
      check($sformatf("vec%0d_mispredict", i), mispredict, vecs[i].mis);
      check($sformatf("vec%0d_upd_we", i), upd_we, vecs[i].we);
      if (vecs[i].we) begin
        check($sformatf("vec%0d_upd_pc", i), upd_pc, vecs[i].upc);
        check($sformatf("vec%0d_upd_taken", i), upd_branch_taken, vecs[i].rt);
      end
    end

    // ---------------- fill the FIFO ----------------
    for (int i = 0; i < 4; i++) step(0, 1, 'h100 + i, i, 1, 0, 0, 0);
    resolve_valid = 0; lookup_valid = 1; #1;
    check("full_ready_low", lookup_ready, 0);
    step(0, 1, 'h1F0, 0, 1, 0, 0, 0);
    check("full_lookup_dropped", pred_valid, 0);
    step(0, 1, 'h1F1, 1, 1, 1, 1, 0);
    check("full_push_pop_pred_valid", pred_valid, 1);
    check("full_push_pop_upd_we", upd_we, 1);
    check("full_push_pop_upd_pc", upd_pc, 'h100);
    resolve_valid = 0; #1;
    check("still_full_ready_low", lookup_ready, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 1, i % 2, 0);
    check("drained_ready", lookup_ready, 1);

    // ---------------- flush with resolve ----------------
    step(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 'h200 + i, 2, 1, 0, 0, 0);
    step(0, 1, 'h2F0, 0, 1, 1, 1, 1);
    check("flush_upd_we", upd_we, 1);
    check("flush_mispredict", mispredict, 1);
    check("flush_upd_pc", upd_pc, 'h200);
    check("flush_lookup_dropped", pred_valid, 0);
    step(0, 0, 0, 0, 0, 1, 0, 0);
    check("underflow_set", err_underflow, 1);
    check("underflow_no_we", upd_we, 0);
    idle();
    check("underflow_sticky", err_underflow, 1);

    // ---------------- reset mid-operation ----------------
    step(0, 1, 'h055, 1, 1, 0, 0, 0);
    step(0, 1, 'h056, 1, 1, 0, 0, 0);
    step(1, 1, 'h057, 1, 1, 1, 1, 0);
    check("midrst_err_cleared", err_underflow, 0);
    check("midrst_pred_valid", pred_valid, 0);
    step(0, 0, 0, 0, 0, 1, 0, 0);
    check("midrst_fifo_empty", err_underflow, 1);

`ifdef PHT_PRED_STATS_EN
    // ---------------- statistics ----------------
    step(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 'h300 + i, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 2; i++) step(0, 1, 'h308 + i, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 1, 1, 0);
    check("stats_resolved_5", stat_resolved, 5);
    check("stats_mispred_2", stat_mispred, 2);
    force dut.stat_resolved_q = 16'hFFFF;
    #1;
    release dut.stat_resolved_q;
    e_sr = 65535;
    step(0, 1, 'h310, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 0);
    check("stats_saturate", stat_resolved, 16'hFFFF);
`else
    check("stats_off_resolved", stat_resolved, 0);
    check("stats_off_mispred", stat_mispred, 0);
`endif

    // ---------------- random traffic ----------------
    step(1, 0, 0, 0, 0, 0, 0, 0);
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 99) == 0,
           $urandom_range(0, 9) < 6,
           (n % 3 == 0) ? int'($urandom_range(0, 3)) * 16 + 5 : int'($urandom_range(0, 1023)),
           int'($urandom_range(0, 7)),
           $urandom_range(0, 1),
           $urandom_range(0, 9) < 4,
           $urandom_range(0, 1),
           $urandom_range(0, 19) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
